// File: rtl/pipe_adder.sv
// pipe_adder: segmented-carry pipelined add/sub/neg/compare unit; optional sticky overflow via PIPE_ADDER_SO_STICKY_EN
package Pu_types;
    typedef enum logic [2:0] {Alu_add, Alu_sub, Alu_neg, Alu_cmp, Alu_cmpl} Alu_op;
    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic ov;
    } Cr_field;
endpackage

module pipe_adder
    import Pu_types::*;
#(
    parameter int DWIDTH = 32,
    parameter int SEGS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  Alu_op             op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              cin,
    input  logic              flush,
    input  logic              so_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] res,
    output logic              cout,
    output Cr_field           cr,
    output logic              so
);
    localparam int W = DWIDTH / (SEGS < 1 ? 1 : SEGS);

    if (SEGS < 1 || SEGS > DWIDTH || DWIDTH % SEGS != 0) begin : g_bad_cfg
        $error("pipe_adder: SEGS must divide DWIDTH and lie in 1..DWIDTH");
    end

    typedef struct packed {
        logic [DWIDTH-1:0] x;
        logic [DWIDTH-1:0] b;
        logic [DWIDTH-1:0] s;
        logic              c;
        Alu_op             op;
    } stage_t;

    stage_t          src  [SEGS];
    stage_t          nxt  [SEGS];
    stage_t          st_q [SEGS];
    stage_t          last;
    logic [SEGS-1:0] v;
    logic [SEGS-1:0] vsrc;
    logic [SEGS:0]   en;
    logic [W:0]      sum;
    logic            n;
    logic            z;
    logic            ovf;
    Cr_field         crf;

    // Stage k adds slice k with the carry handed on by stage k-1; a stage loads when it is empty or its successor loads
    always_comb begin
        sum = '0;
        src[0].x = op == Alu_add ? a : ~a;
        src[0].b = b;
        src[0].s = '0;
        src[0].c = (op == Alu_cmp || op == Alu_cmpl) ? 1'b1 : cin;
        src[0].op = op;
        vsrc[0] = in_valid;
        for (int i = 1; i < SEGS; i++) begin
            src[i] = st_q[i-1];
            vsrc[i] = v[i-1];
        end
        for (int i = 0; i < SEGS; i++) begin
            sum = {1'b0, src[i].x[i*W +: W]} + {1'b0, src[i].b[i*W +: W]} + {{W{1'b0}}, src[i].c};
            nxt[i] = src[i];
            nxt[i].s[i*W +: W] = sum[W-1:0];
            nxt[i].c = sum[W];
        end
        en[SEGS] = out_ready;
        for (int i = SEGS - 1; i >= 0; i--) en[i] = ~v[i] | en[i+1];
    end

    // Pipeline registers; flush only kills valid bits so payloads are never disturbed needlessly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < SEGS; i++) st_q[i] <= '0;
        end else begin
            for (int i = 0; i < SEGS; i++) begin
                if (flush) v[i] <= 1'b0;
                else if (en[i]) v[i] <= vsrc[i];
                if (en[i]) st_q[i] <= nxt[i];
            end
        end
    end

    assign last      = st_q[SEGS-1];
    assign in_ready  = en[0];
    assign out_valid = v[SEGS-1];
    assign res       = last.s;
    assign cout      = last.c;

    // Condition bits from the final sum: compares evaluate b - a, so sign/overflow and carry give the orderings
    always_comb begin
        n = last.s[DWIDTH-1];
        z = ~|last.s;
        ovf = (last.x[DWIDTH-1] == last.b[DWIDTH-1]) && (n != last.x[DWIDTH-1]);
        crf = last.op == Alu_cmp  ? Cr_field'{lt: (n == ovf) && !z, gt: n != ovf, eq: z, ov: 1'b0} :
              last.op == Alu_cmpl ? Cr_field'{lt: last.c && !z, gt: !last.c, eq: z, ov: 1'b0} :
                                    Cr_field'{lt: n, gt: !n && !z, eq: z, ov: ovf};
        cr = out_valid ? crf : '0;
    end

`ifdef PIPE_ADDER_SO_STICKY_EN
    // Sticky overflow: an overflowing consume wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) so <= 1'b0;
        else if (out_valid && out_ready && cr.ov) so <= 1'b1;
        else if (so_clr) so <= 1'b0;
    end
`else
    logic unused_so_clr;
    assign unused_so_clr = so_clr;
    assign so = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard plus directed checks for pipe_adder (SEGS=2 main, SEGS=4 and SEGS=1 side instances)
module tb_pipe_adder;
    import Pu_types::*;
    localparam int S = 2;

    logic        clk = 0;
    logic        reset = 0;
    logic        in_valid, in_ready, cin, flush, so_clr, out_valid, out_ready, cout, so;
    Alu_op       op;
    logic [31:0] a, b, res;
    Cr_field     cr;

    logic        s4_iv, s4_ir, s4_cin, s4_ov, s4_cout, s4_so;
    Alu_op       s4_op;
    logic [31:0] s4_a, s4_b, s4_res;
    Cr_field     s4_cr;

    logic        s1_iv, s1_ir, s1_cin, s1_ov, s1_cout, s1_so;
    Alu_op       s1_op;
    logic [31:0] s1_a, s1_b, s1_res;
    Cr_field     s1_cr;

    always #5 clk = ~clk;

    pipe_adder #(.DWIDTH(32), .SEGS(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .cin(cin), .flush(flush), .so_clr(so_clr), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .cout(cout), .cr(cr), .so(so));

    pipe_adder #(.DWIDTH(32), .SEGS(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(s4_iv), .in_ready(s4_ir), .op(s4_op), .a(s4_a), .b(s4_b),
        .cin(s4_cin), .flush(1'b0), .so_clr(1'b0), .out_valid(s4_ov), .out_ready(1'b1),
        .res(s4_res), .cout(s4_cout), .cr(s4_cr), .so(s4_so));

    pipe_adder #(.DWIDTH(32), .SEGS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(s1_iv), .in_ready(s1_ir), .op(s1_op), .a(s1_a), .b(s1_b),
        .cin(s1_cin), .flush(1'b0), .so_clr(1'b0), .out_valid(s1_ov), .out_ready(1'b1),
        .res(s1_res), .cout(s1_cout), .cr(s1_cr), .so(s1_so));

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic [3:0]  cr;
    } exp_t;

    typedef struct {
        exp_t e;
        int   t;
    } item_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_cons = 0;
    int    base;
    logic  so_m = 0;
    bit    saw_full = 0;
    item_t q[$];

    Alu_op       t_op  [6] = '{Alu_sub, Alu_neg, Alu_add, Alu_cmpl, Alu_sub, Alu_cmp};
    logic [31:0] t_a   [6] = '{32'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h80000000};
    logic [31:0] t_b   [6] = '{32'd3, 32'd0, 32'd1, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic        t_cin [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic for the sum, true signed range for overflow, direct comparisons for cmp/cmpl
    function automatic exp_t model(Alu_op o, logic [31:0] oa, logic [31:0] ob, logic ci);
        exp_t        e;
        logic        cmpop, lt, gt, eq, ov;
        logic [31:0] x;
        logic [32:0] u;
        longint      s, lim;
        cmpop = o == Alu_cmp || o == Alu_cmpl;
        x = o == Alu_add ? oa : ~oa;
        u = {1'b0, x} + {1'b0, ob} + 33'(cmpop | ci);
        s = longint'($signed(x)) + longint'($signed(ob)) + longint'(cmpop | ci);
        lim = 64'sh80000000;
        ov = !cmpop && (s >= lim || s < -lim);
        e.res = u[31:0];
        e.cout = u[32];
        if (o == Alu_cmp) begin
            lt = $signed(oa) < $signed(ob);
            gt = $signed(oa) > $signed(ob);
            eq = oa == ob;
        end else if (o == Alu_cmpl) begin
            lt = oa < ob;
            gt = oa > ob;
            eq = oa == ob;
        end else begin
            lt = e.res[31];
            eq = e.res == 0;
            gt = !lt && !eq;
        end
        e.cr = {lt, gt, eq, ov};
        return e;
    endfunction

    // Per-cycle compare against the model, then advance the model by the handshakes of the coming edge
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            so_m = 0;
        end
        chk("out_valid", out_valid, q.size() > 0 && cyc - q[0].t >= S);
        chk("in_ready", in_ready, out_ready || q.size() < S);
        chk("so", so, so_m);
        if (!in_ready) saw_full = 1;
        if (out_valid && q.size() > 0) begin
            chk("res", res, q[0].e.res);
            chk("cout", cout, q[0].e.cout);
            chk("cr", cr, q[0].e.cr);
        end
        if (reset) begin
`ifdef PIPE_ADDER_SO_STICKY_EN
            if (out_valid && out_ready && q.size() > 0 && q[0].e.cr[0]) so_m = 1;
            else if (so_clr) so_m = 0;
`endif
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_cons++;
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{e: model(op, a, b, cin), t: cyc});
        end
    end

    task automatic send(Alu_op o, logic [31:0] x, logic [31:0] y, logic ci);
        int n = 0;
        op = o; a = x; b = y; cin = ci; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic lit(string nm, Alu_op o, logic [31:0] x, logic [31:0] y, logic ci,
                       logic [31:0] er, logic ec, logic [3:0] ecr, bit has_res);
        @(posedge clk); #1;
        op = o; a = x; b = y; cin = ci; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk({nm, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        if (has_res) begin
            chk({nm, "_res"}, res, er);
            chk({nm, "_cout"}, cout, ec);
        end
        chk({nm, "_cr"}, cr, ecr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op = Alu_add; a = 1; b = 1; cin = 0; in_valid = 1; flush = 0; so_clr = 0; out_ready = 1;
        s4_iv = 0; s4_op = Alu_add; s4_a = 0; s4_b = 0; s4_cin = 0;
        s1_iv = 0; s1_op = Alu_add; s1_a = 0; s1_b = 0; s1_cin = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_cout", cout, 0);
        chk("rst_cr", cr, 0);
        chk("rst_so", so, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s4_valid", s4_ov, 0);
        @(posedge clk); #1;
        reset = 1; in_valid = 0;

        lit("add_carry", Alu_add, 32'h0000FFFF, 32'h1, 1'b0, 32'h00010000, 1'b0, 4'b0100, 1);
        lit("add_ovf", Alu_add, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 4'b1001, 1);
`ifdef PIPE_ADDER_SO_STICKY_EN
        #1 so_clr = 1;
        @(posedge clk); #1;
        so_clr = 0;
        @(negedge clk);
        chk("so_set_wins", so, 1);
        @(posedge clk); #1;
        so_clr = 1;
        @(posedge clk); #1;
        so_clr = 0;
        @(negedge clk);
        chk("so_clear", so, 0);
`endif
        lit("cmp_lt", Alu_cmp, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 4'b1000, 0);
        lit("cmpl_gt", Alu_cmpl, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 4'b0100, 0);
        lit("cmp_eq", Alu_cmp, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 4'b0010, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(t_op[i], t_a[i], t_b[i], t_cin[i]);
        repeat (4) @(posedge clk);
        #1;

        base = n_cons;
        saw_full = 0;
        fork
            for (int i = 0; i < 8; i++) send(Alu_add, 32'h100 * i, i, i[0]);
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                out_ready = !(c >= 2 && c <= 5);
            end
        join
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_count", n_cons - base, 8);
        chk("b2b_full_seen", saw_full, 1);

        base = n_cons;
        op = Alu_add; a = 1; b = 1; cin = 0; in_valid = 1;
        @(posedge clk); #1;
        a = 2; flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush1_valid", out_valid, 0);
        chk("flush1_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("flush1_none", n_cons - base, 0);

        out_ready = 0;
        a = 10; in_valid = 1;
        @(posedge clk); #1;
        a = 11;
        @(posedge clk); #1;
        a = 12; flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("flush2_valid", out_valid, 0);
        chk("flush2_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("flush2_none", n_cons - base, 0);

        a = 20; b = 0; in_valid = 1;
        @(posedge clk); #1;
        a = 21;
        @(posedge clk); #1;
        in_valid = 0;
        #1 reset = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_cr", cr, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1; op = Alu_add; a = 1; b = 2; cin = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_res", res, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_none_lost", n_cons - base, 1);

        s4_op = Alu_sub; s4_a = 1; s4_b = 0; s4_cin = 1; s4_iv = 1;
        @(posedge clk); #1;
        s4_iv = 0;
        repeat (3) @(negedge clk);
        chk("s4_early", s4_ov, 0);
        @(negedge clk);
        chk("s4_valid", s4_ov, 1);
        chk("s4_res", s4_res, 32'hFFFFFFFF);
        chk("s4_cout", s4_cout, 0);
        chk("s4_cr", s4_cr, 4'b1000);

        @(posedge clk); #1;
        s1_op = Alu_add; s1_a = 3; s1_b = 4; s1_cin = 1; s1_iv = 1;
        @(posedge clk); #1;
        s1_iv = 0;
        @(negedge clk);
        chk("s1_valid", s1_ov, 1);
        chk("s1_res", s1_res, 8);
        chk("s1_cr", s1_cr, 4'b0100);
        @(negedge clk);
        chk("s1_drained", s1_ov, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter DWIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SEGS, default 2, number of carry segments = pipeline stages; DWIDTH % SEGS == 0 and 1 <= SEGS <= DWIDTH SHALL hold, else elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 op  input  Pu_types::Alu_op  one of Alu_add, Alu_sub, Alu_neg, Alu_cmp, Alu_cmpl.
REQ-008 a, b  input  DWIDTH each  operands.
REQ-009 cin  input  1  carry in (ignored for Alu_cmp/Alu_cmpl).
REQ-010 flush  input  1  discard all in-flight operations.
REQ-011 so_clr  input  1  clear sticky summary overflow.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 res  output  DWIDTH  sum.
REQ-015 cout  output  1  carry out of MSB.
REQ-016 cr  output  Pu_types::Cr_field  lt/gt/eq/ov condition bits.
REQ-017 so  output  1  sticky summary overflow.

Function
REQ-018 Arithmetic: res = (a XOR {DWIDTH{inv}}) + b + c, inv = 1 for sub/neg/cmp/cmpl else 0; c = 1 for cmp/cmpl, else cin.
REQ-019 Stage k (0..SEGS-1) SHALL add bit slice k of width DWIDTH/SEGS using the carry registered from stage k-1; higher slices of a, b, op travel unmodified in pipeline registers.
REQ-020 Latency SHALL be exactly SEGS cycles from accepted input to out_valid with no back-pressure; throughput one operation per cycle.
REQ-021 Input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-022 in_ready = out_ready | ~(all stages valid); a stage advances when the next stage is empty or advancing (bubble collapse).
REQ-023 While out_valid & ~out_ready, res, cout, cr SHALL hold stable.
REQ-024 cout = carry out of MSB; cr.ov = signed overflow for add/sub/neg, forced 0 for cmp/cmpl.
REQ-025 add/sub/neg: exactly one of lt/gt/eq set from result (negative/positive/zero).
REQ-026 cmp: lt = a<b signed, gt = a>b signed, eq = a==b; cmpl: same unsigned; exactly one set.
REQ-027 flush SHALL clear every stage valid bit at the next edge; an input presented with flush the same cycle SHALL be discarded; in_ready SHALL be 1 in the cycle after flush.
REQ-028 Simultaneous accept and consume with all stages full SHALL proceed without a bubble.
REQ-029 SEGS = 1 SHALL yield a single registered stage, latency 1.

Reset
REQ-030 While reset = 0: all valid bits, out_valid, res, cout, cr, so SHALL be 0; in_ready SHALL be 1.
REQ-031 Reset assertion mid-operation SHALL discard all in-flight operations; first accept possible in first cycle after deassertion.

Configuration
REQ-032 Macro PIPE_ADDER_SO_STICKY_EN defined: so register SHALL set on consume of any result with cr.ov = 1 and clear on so_clr; so_clr with a simultaneous overflowing consume SHALL leave so = 1.
REQ-033 Macro undefined: so SHALL be constant 0, so_clr ignored, no sticky register synthesised.

Verification
REQ-034 DWIDTH=32, SEGS=2: add a=0x0000FFFF, b=0x00000001, cin=0 -> after 2 cycles res=0x00010000, cout=0, cr.gt=1, cr.ov=0.
REQ-035 add a=0x7FFFFFFF, b=1 -> res=0x80000000, cr.lt=1, cr.ov=1; with PIPE_ADDER_SO_STICKY_EN so=1 until so_clr pulse.
REQ-036 cmp a=0xFFFFFFFF, b=1 -> cr.lt=1; cmpl same operands -> cr.gt=1; cmp a=b=5 -> cr.eq=1, cr.ov=0.
REQ-037 Back-to-back 8 ops with out_ready=0 for cycles 3-6 -> in_ready low once full, no loss/duplication, results in order.
REQ-038 flush with 2 ops in flight plus one presented -> out_valid 0 next cycle, none of the 3 ever emerge.
REQ-039 SEGS=4, sub a=1, b=0, cin=1 -> after 4 cycles res=0xFFFFFFFF, cout=0, cr.lt=1.
